// File: rtl/ifetch_mem_responder_if.sv
// Fetch handshake (cache side) and byte-wide RAM bus (arbiter side) of the
// instruction-fetch memory responder.
interface ifetch_mem_responder_if;
    logic        asking;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] data;
    logic        data_ready;
    logic        bus_req;
    logic        bus_grant;
    logic [31:0] mem_a;
    logic        mem_rd_en;
    logic [7:0]  mem_din;

    modport slave (
        input  asking, addr, flush, bus_grant, mem_din,
        output data, data_ready, bus_req, mem_a, mem_rd_en
    );

    modport master (
        output asking, addr, flush, bus_grant, mem_din,
        input  data, data_ready, bus_req, mem_a, mem_rd_en
    );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch memory responder: wins the byte-wide RAM bus and assembles
// one 16-bit (RVC) or 32-bit little-endian instruction per request.
module ifetch_mem_responder #(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    ifetch_mem_responder_if.slave ifc
);
    localparam int LAST = MEM_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, REQ, READ} state_t;

    state_t      state;
    logic [31:0] base;
    logic [1:0]  issue_k;
    logic        issue_done;
    logic        b0_known;
    logic [7:0]  b0_q, b1_q, b2_q;

    // Read-return tracker: entry LAST holds the byte whose data is on mem_din now
    logic [MEM_LATENCY-1:0] rd_vld_p;
    logic [1:0]             rd_idx_p [MEM_LATENCY];

    logic       samp, b0_now, b0_avail, b0_is32, issue_fire, done_now;
    logic [1:0] samp_idx, issue_byte;

    always_comb begin
        samp       = (state == READ) && rd_vld_p[LAST];
        samp_idx   = rd_idx_p[LAST];
        b0_now     = samp && (samp_idx == 2'd0);
        b0_avail   = b0_known || b0_now;
        // Length decision may be needed on the very edge byte0 arrives
        b0_is32    = b0_known ? (b0_q[1:0] == 2'b11) : (ifc.mem_din[1:0] == 2'b11);
        issue_byte = (state == READ) ? issue_k : 2'd0;
        issue_fire = 1'b0;
        if (!ifc.flush) begin
            if (state == REQ)
                issue_fire = ifc.bus_grant;
            else if (state == READ && !issue_done)
                issue_fire = (issue_k == 2'd1) || (b0_avail && b0_is32);
        end
        done_now = samp && !ifc.flush &&
                   ((samp_idx == 2'd3) || (samp_idx == 2'd1 && b0_q[1:0] != 2'b11));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ifc.bus_req    <= 1'b0;
            ifc.mem_a      <= '0;
            ifc.mem_rd_en  <= 1'b0;
            ifc.data       <= '0;
            ifc.data_ready <= 1'b0;
            issue_k        <= 2'd0;
            issue_done     <= 1'b0;
            b0_known       <= 1'b0;
            rd_vld_p       <= '0;
        end else begin
            ifc.data_ready <= 1'b0;
            ifc.mem_rd_en  <= issue_fire;
            if (issue_fire)
                ifc.mem_a <= base + {30'd0, issue_byte};
            for (int i = LAST; i > 0; i--)
                rd_vld_p[i] <= rd_vld_p[i-1];
            rd_vld_p[0] <= issue_fire;

            if (ifc.flush) begin
                state       <= IDLE;
                ifc.bus_req <= 1'b0;
                rd_vld_p    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ifc.asking) begin
                            state       <= REQ;
                            ifc.bus_req <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (ifc.bus_grant) begin
                            state      <= READ;
                            issue_k    <= 2'd1;
                            issue_done <= 1'b0;
                            b0_known   <= 1'b0;
                        end
                    end
                    READ: begin
                        if (b0_now)
                            b0_known <= 1'b1;
                        if (issue_fire) begin
                            if (issue_k == 2'd3)
                                issue_done <= 1'b1;
                            else
                                issue_k <= issue_k + 2'd1;
                        end else if (issue_k != 2'd1 && b0_avail && !b0_is32) begin
                            issue_done <= 1'b1;
                        end
                        if (done_now) begin
                            ifc.data       <= (samp_idx == 2'd3) ?
                                              {ifc.mem_din, b2_q, b1_q, b0_q} :
                                              {16'h0000, ifc.mem_din, b0_q};
                            ifc.data_ready <= 1'b1;
                            ifc.bus_req    <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && ifc.asking)
            base <= ifc.addr;
        for (int i = LAST; i > 0; i--)
            rd_idx_p[i] <= rd_idx_p[i-1];
        rd_idx_p[0] <= issue_byte;
        if (samp) begin
            case (samp_idx)
                2'd0:    b0_q <= ifc.mem_din;
                2'd1:    b1_q <= ifc.mem_din;
                2'd2:    b2_q <= ifc.mem_din;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Bench for ifetch_mem_responder: two instances (MEM_LATENCY 1 and 3) driven by
// table vectors, hand sequences and random fetches against a schedule model.
module tb_ifetch_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        asking = 1'b0;
    logic        flush = 1'b0;
    logic        bus_grant = 1'b0;
    logic [31:0] addr = '0;

    ifetch_mem_responder_if if1 ();
    ifetch_mem_responder_if if3 ();

    assign if1.asking = asking;  assign if3.asking = asking;
    assign if1.addr = addr;      assign if3.addr = addr;
    assign if1.flush = flush;    assign if3.flush = flush;
    assign if1.bus_grant = bus_grant;
    assign if3.bus_grant = bus_grant;

    ifetch_mem_responder #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .ifc(if1.slave));
    ifetch_mem_responder #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .ifc(if3.slave));

    // RAM models: byte appears on mem_din exactly L edges after its address was driven
    logic [7:0]  ram [1024];
    logic [31:0] hist3 [2];
    always @(posedge clk) begin
        hist3[0] <= if3.mem_a;
        hist3[1] <= hist3[0];
    end
    always @(negedge clk) begin
        if1.mem_din <= ram[if1.mem_a[9:0]];
        if3.mem_din <= ram[hist3[1][9:0]];
    end

    int sel = 0;
    logic        o_req, o_rd, o_dr;
    logic [31:0] o_a, o_data;
    always_comb begin
        if (sel == 1) begin
            o_req = if3.bus_req; o_rd = if3.mem_rd_en; o_dr = if3.data_ready;
            o_a = if3.mem_a; o_data = if3.data;
        end else begin
            o_req = if1.bus_req; o_rd = if1.mem_rd_en; o_dr = if1.data_ready;
            o_a = if1.mem_a; o_data = if1.data;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic put4(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] ak;
        ak = a;        ram[ak[9:0]] = b0;
        ak = a + 32'd1; ram[ak[9:0]] = b1;
        ak = a + 32'd2; ram[ak[9:0]] = b2;
        ak = a + 32'd3; ram[ak[9:0]] = b3;
    endtask

    // Reference: instruction length from byte0, issue edges relative to grant edge,
    // completion edge = last byte's issue edge + latency.
    function automatic void model(input logic [31:0] a, input int lat, output logic [31:0] d,
                                  output int comp, output int s2);
        logic [7:0]  b [4];
        logic [31:0] ak;
        for (int k = 0; k < 4; k++) begin
            ak = a + 32'(k);
            b[k] = ram[ak[9:0]];
        end
        if (b[0][1:0] == 2'b11) begin
            s2   = (lat > 2) ? lat : 2;
            d    = {b[3], b[2], b[1], b[0]};
            comp = s2 + 1 + lat;
        end else begin
            s2   = -100;
            d    = {16'h0000, b[1], b[0]};
            comp = 1 + lat;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; asking = 1'b0; flush = 1'b0; bus_grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_data = '0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input int lsel, input int gd, input int f,
                            input bit hold, input bit drop, input logic [31:0] exp_d,
                            input int exp_comp);
        logic [31:0] md;
        int mc, s2, k, last, off;
        bit e_req, e_rd, e_dr;
        if (lsel != sel) begin
            sel = lsel;
            do_reset();
        end
        model(a, (lsel == 1) ? 3 : 1, md, mc, s2);
        last = (f >= 0) ? gd + f + 1 : gd + exp_comp + 1;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            asking    = (n == 0) || hold;
            addr      = a;
            bus_grant = (n >= gd) && (n == gd || !drop) && (n <= gd + exp_comp);
            flush     = (f >= 0) && (n == gd + f);
            @(posedge clk);
            #1;
            k = n - gd;
            e_rd = 1'b0; e_dr = 1'b0; off = 0;
            if (k < 0) begin
                e_req = 1'b1;
            end else if (f >= 0 && k >= f) begin
                e_req = 1'b0;
            end else if (k < exp_comp) begin
                e_req = 1'b1;
                if (k < 2) begin
                    e_rd = 1'b1; off = k;
                end else if (k == s2 || k == s2 + 1) begin
                    e_rd = 1'b1; off = k - s2 + 2;
                end
            end else if (k == exp_comp) begin
                e_req = 1'b0; e_dr = 1'b1; last_data = exp_d;
            end else begin
                e_req = hold;
            end
            chk("bus_req", {31'd0, o_req}, {31'd0, e_req});
            chk("mem_rd_en", {31'd0, o_rd}, {31'd0, e_rd});
            chk("data_ready", {31'd0, o_dr}, {31'd0, e_dr});
            chk("data", o_data, last_data);
            if (e_rd) chk("mem_a", o_a, a + 32'(off));
        end
        @(negedge clk);
        asking = 1'b0; bus_grant = 1'b0; flush = hold;
        if (hold) begin
            @(posedge clk);
            #1;
            chk("bus_req_after_flush", {31'd0, o_req}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [7:0]  b0, b1, b2, b3;
        int          lsel, gd, f;
        bit          hold;
        logic [31:0] exp_d;
        int          exp_comp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rd;
        int rc, rs2, rl, rg, rf;
        bit rh, rdp;

        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);

        vecs[0] = '{32'h0000_0100, 8'h13, 8'h05, 8'h10, 8'h00, 0, 1, -1, 1'b0, 32'h0010_0513, 4};
        vecs[1] = '{32'h0000_0202, 8'h01, 8'h45, 8'hAA, 8'hBB, 0, 1, -1, 1'b0, 32'h0000_4501, 2};
        vecs[2] = '{32'h0000_0300, 8'h93, 8'h00, 8'h10, 8'h00, 0, 2, 2, 1'b0, 32'h0, 4};
        vecs[3] = '{32'hFFFF_FFFE, 8'h37, 8'h04, 8'h00, 8'h00, 0, 1, -1, 1'b0, 32'h0000_0437, 4};
        vecs[4] = '{32'h0000_0120, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 3, -1, 1'b1, 32'hFFFF_FFFF, 4};
        vecs[5] = '{32'h0000_0400, 8'hB3, 8'h82, 8'h01, 8'h00, 1, 1, -1, 1'b1, 32'h0001_82B3, 7};
        vecs[6] = '{32'h0000_0410, 8'h05, 8'h45, 8'h77, 8'h66, 1, 2, -1, 1'b0, 32'h0000_4505, 4};
        vecs[7] = '{32'h0000_0500, 8'h13, 8'h01, 8'h02, 8'h03, 1, 1, 3, 1'b0, 32'h0, 7};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_bus_req", {31'd0, o_req}, 32'd0);
            chk("rst_rd_en", {31'd0, o_rd}, 32'd0);
            chk("rst_data_ready", {31'd0, o_dr}, 32'd0);
            chk("rst_mem_a", o_a, 32'd0);
            chk("rst_data", o_data, 32'd0);
        end
        sel = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            put4(vecs[i].a, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            do_fetch(vecs[i].a, vecs[i].lsel, vecs[i].gd, vecs[i].f, vecs[i].hold, 1'b0,
                     vecs[i].exp_d, vecs[i].exp_comp);
        end

        // Asynchronous reset in the middle of a read
        if (sel != 0) begin
            sel = 0;
            do_reset();
        end
        put4(32'h0000_0600, 8'h13, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        asking = 1'b1; addr = 32'h0000_0600;
        @(negedge clk);
        asking = 1'b0; bus_grant = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bus_req", {31'd0, o_req}, 32'd0);
        chk("arst_rd_en", {31'd0, o_rd}, 32'd0);
        chk("arst_data_ready", {31'd0, o_dr}, 32'd0);
        chk("arst_mem_a", o_a, 32'd0);
        chk("arst_data", o_data, 32'd0);
        @(negedge clk);
        bus_grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_data = '0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            chk("post_rst_data_ready", {31'd0, o_dr}, 32'd0);
            chk("post_rst_bus_req", {31'd0, o_req}, 32'd0);
            chk("post_rst_rd_en", {31'd0, o_rd}, 32'd0);
        end

        // Random fetches
        for (int it = 0; it < 40; it++) begin
            rl = int'($urandom_range(0, 1));
            rg = int'($urandom_range(1, 3));
            ra = $urandom & 32'hFFFF_FFFE;
            put4(ra, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            model(ra, (rl == 1) ? 3 : 1, rd, rc, rs2);
            rf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(rc - 1))) : -1;
            rh  = (rf < 0) && ($urandom_range(0, 3) == 0);
            rdp = 1'($urandom_range(0, 1));
            do_fetch(ra, rl, rg, rf, rh, rdp, rd, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
